// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions for the task2 datapath (key scheduling, PRGA,
// top-level controller).
//   byte_t       : ARC4 byte
//   prga_state_e : PRGA FSM states
//   S_SIZE       : number of entries in the S permutation
package arc4_pkg;

  typedef logic [7:0] byte_t;

  localparam int S_SIZE = 256;

  typedef enum logic [3:0] {
    P_IDLE,
    P_RD_LEN,
    P_CAP_LEN,
    P_RD_I,
    P_CAP_I,
    P_CAP_J,
    P_WR_I,
    P_WR_J,
    P_RD_PAD,
    P_WR_PT
  } prga_state_e;

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation + decrypt stage.
// Reads a length-prefixed ciphertext from CT memory, runs the ARC4 keystream
// over the S permutation left by key scheduling (mutating S in place), and
// writes the length-prefixed plaintext to PT memory.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   en / rdy              start request / idle indication
//   s_addr/s_rddata/s_wrdata/s_wren   S memory (sync read, 1-cycle latency)
//   ct_addr/ct_rddata     CT memory (read only)
//   pt_addr/pt_wrdata/pt_wren         PT memory (write only)
module prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  prga_state_e state_q, state_d;
  byte_t i_q, i_d;
  byte_t j_q, j_d;
  byte_t k_q, k_d;
  byte_t len_q, len_d;
  byte_t si_q, si_d;
  byte_t sj_q, sj_d;
  byte_t ct_q, ct_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= P_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      ct_q    <= ct_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    ct_d      = ct_q;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;

    unique case (state_q)
      P_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          // ct_addr is already 0 here: the length byte is being fetched.
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = P_RD_LEN;
        end
      end
      // ct_addr stays 0, so ct_rddata still holds the length next cycle.
      P_RD_LEN: state_d = P_CAP_LEN;
      P_CAP_LEN: begin
        len_d     = ct_rddata;
        pt_addr   = '0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        if (ct_rddata == 8'd0) begin
          state_d = P_IDLE;
        end else begin
          k_d     = 8'd1;
          state_d = P_RD_I;
        end
      end
      P_RD_I: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_q + 8'd1;
        ct_addr = k_q;
        state_d = P_CAP_I;
      end
      P_CAP_I: begin
        si_d    = s_rddata;
        ct_d    = ct_rddata;
        j_d     = j_q + s_rddata;
        s_addr  = j_q + s_rddata;
        state_d = P_CAP_J;
      end
      P_CAP_J: begin
        sj_d    = s_rddata;
        state_d = P_WR_I;
      end
      // When i==j both writes store the same byte, leaving S unchanged.
      P_WR_I: begin
        s_addr   = i_q;
        s_wrdata = sj_q;
        s_wren   = 1'b1;
        state_d  = P_WR_J;
      end
      P_WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = P_RD_PAD;
      end
      // Pre-swap si+sj equals post-swap S[i]+S[j].
      P_RD_PAD: begin
        s_addr  = si_q + sj_q;
        state_d = P_WR_PT;
      end
      P_WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ ct_q;
        pt_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = P_IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = P_RD_I;
        end
      end
      default: state_d = P_IDLE;
    endcase
  end

endmodule
